// File: rtl/convert_sequencer_pkg.sv
// Shared definitions for the convert_sequencer session controller: state
// encoding, result mask, digit limit and watchdog counter sizing.
package seq_pkg;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_START = 3'd1;
   localparam logic [2:0] ST_WAIT  = 3'd2;
   localparam logic [2:0] ST_DONE  = 3'd3;
   localparam logic [2:0] ST_ERR   = 3'd4;

   typedef enum logic [2:0] {
      IDLE  = ST_IDLE,
      START = ST_START,
      WAIT  = ST_WAIT,
      DONE  = ST_DONE,
      ERR   = ST_ERR
   } seq_state_t;

   localparam logic [7:0] MASK_RESULT = 8'hF0;
   localparam logic [3:0] MAX_DIGITS  = 4'd8;

   // Counter width able to hold TIMEOUT_CYCLES-1; never narrower than one bit.
   function automatic int wd_width(input int cycles);
      return (cycles <= 2) ? 1 : $clog2(cycles);
   endfunction

endpackage

// File: rtl/convert_sequencer_watchdog.sv
// WAIT-state watchdog: clears on request, counts while enabled and flags the
// last allowed cycle. Built only with CONVERT_SEQUENCER_TIMEOUT_EN.
module seq_watchdog
   import seq_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int W = wd_width(TIMEOUT_CYCLES);
   localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

   logic [W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && count != LAST) begin
         count <= count + 1'b1;
      end
   end

   assign expired = enable && (count == LAST);

endmodule

// File: rtl/convert_sequencer.sv
// Session controller for the 16-bit IEEE754 converter: collects digits, starts
// one conversion per confirm and latches the result or error for the display.
// Optional watchdog in WAIT: define CONVERT_SEQUENCER_TIMEOUT_EN.
//
// Handshake: conv_start is a one-cycle request with conv_data stable from that
// cycle on; conv_ready / conv_error are single-cycle responses sampled in WAIT
// only, error taking precedence; clear_pulse overrides everything.
module convert_sequencer
   import seq_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1_000_000,
   parameter int MIN_DIGITS     = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enter_pulse,
   input  logic        confirm_pulse,
   input  logic        clear_pulse,
   input  logic [31:0] numb,
   input  logic [7:0]  mask_in,
   input  logic        conv_ready,
   input  logic [15:0] conv_result,
   input  logic        conv_error,
   output logic        conv_start,
   output logic        conv_reset,
   output logic [15:0] conv_data,
   output logic [31:0] show,
   output logic [7:0]  mask,
   output logic        error,
   output logic        busy,
   output logic [3:0]  digits,
   output logic [2:0]  state_dbg
);

   localparam logic [3:0] MIN_D = 4'(MIN_DIGITS);

   seq_state_t  state_q, state_d;
   logic        conv_start_d, conv_reset_d, error_d, busy_d;
   logic [15:0] conv_data_d;
   logic [31:0] show_d;
   logic [7:0]  mask_d;
   logic [3:0]  digits_d;
   logic        wd_expired;

`ifdef CONVERT_SEQUENCER_TIMEOUT_EN
   seq_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (state_q == START),
      .enable  (state_q == WAIT),
      .expired (wd_expired)
   );
`else
   assign wd_expired = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         conv_start <= 1'b0;
         conv_reset <= 1'b0;
         conv_data  <= '0;
         show       <= '0;
         mask       <= '0;
         error      <= 1'b0;
         busy       <= 1'b0;
         digits     <= '0;
      end else begin
         state_q    <= state_d;
         conv_start <= conv_start_d;
         conv_reset <= conv_reset_d;
         conv_data  <= conv_data_d;
         show       <= show_d;
         mask       <= mask_d;
         error      <= error_d;
         busy       <= busy_d;
         digits     <= digits_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      conv_start_d = 1'b0;
      conv_reset_d = 1'b0;
      conv_data_d  = conv_data;
      show_d       = show;
      mask_d       = mask;
      error_d      = error;
      busy_d       = 1'b0;
      digits_d     = digits;
      if (clear_pulse) begin
         state_d      = IDLE;
         conv_reset_d = 1'b1;
         conv_data_d  = '0;
         show_d       = '0;
         error_d      = 1'b0;
         digits_d     = '0;
      end else begin
         case (state_q)
            IDLE: begin
               show_d = numb;
               mask_d = mask_in;
               if (enter_pulse && digits < MAX_DIGITS) digits_d = digits + 4'd1;
               if (confirm_pulse && digits >= MIN_D) begin
                  conv_data_d  = numb[15:0];
                  conv_start_d = 1'b1;
                  busy_d       = 1'b1;
                  state_d      = START;
               end
            end
            START: begin
               busy_d  = 1'b1;
               state_d = WAIT;
            end
            WAIT: begin
               busy_d = 1'b1;
               // A real response in the final watchdog cycle still wins.
               if (conv_error || (!conv_ready && wd_expired)) begin
                  error_d = 1'b1;
                  busy_d  = 1'b0;
                  state_d = ERR;
               end else if (conv_ready) begin
                  show_d  = {16'h0000, conv_result};
                  mask_d  = MASK_RESULT;
                  busy_d  = 1'b0;
                  state_d = DONE;
               end
            end
            DONE: state_d = DONE;
            ERR:  error_d = 1'b1;
            default: state_d = IDLE;
         endcase
      end
   end

   assign state_dbg = state_q;

endmodule

// File: doc/convert_sequencer.md
# convert_sequencer

Session controller for the IEEE754 conversion datapath on the board. It takes the debounced enter/confirm/clear pulses and the shift-register contents, and starts the 16-bit converter with a single-cycle request. It then waits for the converter's ready or error response and latches the result. It drives the value, digit mask and error flag shown on the 7-segment controller, replacing the loose control registers around the converter with one explicit state machine.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1_000_000: watchdog limit in WAIT, in clk cycles (10 ms at 100 MHz); only used with the watchdog compiled in.
- MIN_DIGITS, 4: number of entered nibbles required before confirm is accepted (range 1..8).

Ports:
- clk  in  1  system clock (100 MHz).
- rst_n  in  1  asynchronous, active-low reset.
- enter_pulse  in  1  one-cycle debounced enter strobe (a nibble was shifted in).
- confirm_pulse  in  1  one-cycle debounced confirm strobe.
- clear_pulse  in  1  one-cycle debounced user-reset strobe.
- numb  in  32  shift-register contents.
- mask_in  in  8  digit mask from the shift register.
- conv_ready  in  1  converter result valid (single-cycle).
- conv_result  in  16  converter output.
- conv_error  in  1  converter error (single-cycle).
- conv_start  out  1  converter request, one-cycle pulse.
- conv_reset  out  1  converter synchronous reset, one-cycle pulse.
- conv_data  out  16  operand for the converter.
- show  out  32  value sent to the segment controller.
- mask  out  8  digit blank mask; bit i = 1 blanks digit i.
- error  out  1  sticky error indication.
- busy  out  1  high in START and WAIT.
- digits  out  4  entered-nibble count, saturates at 8.

## Operation
- States: IDLE, START, WAIT, DONE, ERR. All outputs are registered.
- IDLE:
  - show <= numb and mask <= mask_in every cycle.
  - enter_pulse increments digits, saturating at 8.
  - confirm_pulse with digits >= MIN_DIGITS: latch conv_data <= numb[15:0], then go to START. Otherwise confirm is ignored.
- START (exactly one cycle): conv_start = 1, then go to WAIT.
- WAIT: busy = 1.
  - conv_error: go to ERR and set error <= 1.
  - conv_ready (without error): go to DONE with show <= {16'h0000, conv_result} and mask <= 8'hF0.
  - conv_ready and conv_error in the same cycle: ERR wins.
- DONE: holds show, mask and conv_data. Confirm and enter are ignored; digits does not change.
- ERR: error = 1; show and mask hold their last values. Confirm and enter are ignored.
- clear_pulse in any state has the highest priority:
  - next state IDLE; conv_reset = 1 for one cycle;
  - digits <= 0, error <= 0, show <= 0, conv_data <= 0.
  - A clear arriving in the same cycle as confirm, ready or error overrides it.
- Only clear or rst_n leaves DONE or ERR.

## Timing
- Reset (rst_n low): state IDLE and every output 0, including mask = 8'h00 and digits = 0.
- Outputs are valid from the first clk edge after rst_n deasserts.
- show tracks numb in IDLE with one cycle of latency.
- confirm sampled at edge N: conv_start is high during cycle N+1 only, and conv_data is valid from N+1.
- conv_ready sampled at edge M: show, mask and state DONE are updated at M+1; busy falls at M+1.
- conv_reset is asserted the cycle after clear is sampled, for exactly one cycle.

## Configuration
- CONVERT_SEQUENCER_TIMEOUT_EN defined:
  - a watchdog counter clears on entering WAIT and increments every WAIT cycle;
  - at count TIMEOUT_CYCLES-1 without a response, the block goes to ERR with error = 1;
  - a response in that same cycle takes priority over the timeout.
- Not defined: no counter is built, and WAIT waits indefinitely for ready or error.

## Structure
- Shared package seq_pkg holds:
  - the state encoding (3-bit localparams IDLE..ERR);
  - MASK_RESULT = 8'hF0;
  - MAX_DIGITS = 8;
  - the watchdog counter width function (clog2 of TIMEOUT_CYCLES).
- One sub-module, seq_watchdog: counter with clear/enable/expired, instantiated only under CONVERT_SEQUENCER_TIMEOUT_EN.

## Test plan
- Four enter pulses with numb = 32'h00003C00, then confirm → conv_start pulses once, conv_data = 16'h3C00, busy = 1. Model ready with result 16'h1234 → show = 32'h00001234, mask = 8'hF0, state DONE, busy = 0.
- Two enter pulses then confirm (MIN_DIGITS = 4) → no conv_start, state stays IDLE, show follows numb.
- In WAIT, assert conv_ready and conv_error in the same cycle → state ERR, error = 1, show unchanged.
- In DONE, pulse clear → conv_reset high one cycle, state IDLE, show = 0, digits = 0, error = 0. A subsequent confirm with 4 digits starts a new conversion.
- With the macro defined and TIMEOUT_CYCLES = 16, no converter response → error rises exactly 16 cycles after entering WAIT. Without the macro, state is still WAIT after 1000 cycles.
- Assert rst_n low in WAIT → all outputs 0 immediately. After release, a late conv_ready is ignored and the state stays IDLE.
